// File: rtl/rle_pkg.sv
// Shared definitions for the RLE stream decoder: default widths, run-state
// encoding and instruction field extraction helpers.
package rle_pkg;

    localparam int unsigned RLE_RUN_W_DEF       = 11;
    localparam int unsigned RLE_COLOR_W_DEF     = 9;
    localparam int unsigned RLE_FIFO_DEPTH_DEF  = 2;
    localparam int unsigned RLE_BLANK_COLOR_DEF = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } rle_state_e;

    // Instructions are zero-extended to 64 bits so one helper serves any width.
    function automatic logic [63:0] get_run(input logic [63:0] instr,
                                            input int unsigned color_w);
        return instr >> color_w;
    endfunction

    function automatic logic [63:0] get_color(input logic [63:0] instr,
                                              input int unsigned color_w);
        return instr & ((64'd1 << color_w) - 64'd1);
    endfunction

endpackage

// File: rtl/rle_instr_fifo.sv
// Synchronous instruction prefetch FIFO with combinational head read and a
// synchronous flush that clears occupancy.
module rle_instr_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/rle_stream_decoder.sv
// Streams packed {run, color} instructions out as one color per pixel strobe.
// Optional macro RLE_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter.
module rle_stream_decoder
    import rle_pkg::*;
#(
    parameter int unsigned         RUN_W       = RLE_RUN_W_DEF,
    parameter int unsigned         COLOR_W     = RLE_COLOR_W_DEF,
    parameter int unsigned         FIFO_DEPTH  = RLE_FIFO_DEPTH_DEF,
    parameter logic [COLOR_W-1:0]  BLANK_COLOR = COLOR_W'(RLE_BLANK_COLOR_DEF)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RUN_W+COLOR_W-1:0]      instr_data,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic                          pixel_en,
    input  logic                          blank,
    input  logic                          frame_start,
    output logic [COLOR_W-1:0]            color_out,
    output logic                          color_valid,
    output logic                          underrun,
`ifdef RLE_UNDERRUN_CNT_EN
    output logic [15:0]                   underrun_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned INSTR_W = RUN_W + COLOR_W;

    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [INSTR_W-1:0] fifo_rdata;
    logic [RUN_W-1:0]   head_run;
    logic [COLOR_W-1:0] head_color;

    rle_state_e         state_q, state_d;
    logic [RUN_W-1:0]   count_q, count_d;
    logic [COLOR_W-1:0] cur_color_q, cur_color_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               valid_q, valid_d;
    logic               und_q, und_d;

    assign instr_ready = !fifo_full && !frame_start;
    assign fifo_push   = instr_valid && instr_ready;
    assign head_run    = RUN_W'(get_run(64'(fifo_rdata), COLOR_W));
    assign head_color  = COLOR_W'(get_color(64'(fifo_rdata), COLOR_W));

    rle_instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (frame_start),
        .push_i  (fifo_push),
        .wdata_i (instr_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cur_color_d = cur_color_q;
        color_d     = color_q;
        valid_d     = valid_q;
        und_d       = 1'b0;
        fifo_pop    = 1'b0;
        if (frame_start) begin
            state_d = ST_IDLE;
            count_d = '0;
            color_d = BLANK_COLOR;
            valid_d = 1'b0;
        end else begin
            if (pixel_en) begin
                if (blank) begin
                    color_d = BLANK_COLOR;
                    valid_d = 1'b0;
                end else if (state_q == ST_RUN) begin
                    color_d = cur_color_q;
                    valid_d = 1'b1;
                    if (count_q != '0) begin
                        count_d = count_q - RUN_W'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next run so no bubble appears.
                        fifo_pop    = 1'b1;
                        cur_color_d = head_color;
                        count_d     = head_run;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    color_d = BLANK_COLOR;
                    valid_d = 1'b0;
                    und_d   = 1'b1;
                end
            end
            if (state_q == ST_IDLE && !fifo_empty) begin
                fifo_pop    = 1'b1;
                cur_color_d = head_color;
                count_d     = head_run;
                state_d     = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            cur_color_q <= BLANK_COLOR;
            color_q     <= BLANK_COLOR;
            valid_q     <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            cur_color_q <= cur_color_d;
            color_q     <= color_d;
            valid_q     <= valid_d;
            und_q       <= und_d;
        end
    end

    assign color_out   = color_q;
    assign color_valid = valid_q;
    assign underrun    = und_q;

`ifdef RLE_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Counts alongside the pulse, so the value updates on the same edge.
    always_comb begin
        ucnt_d = ucnt_q;
        if (frame_start)
            ucnt_d = '0;
        else if (und_d && ucnt_q != '1)
            ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ucnt_q <= '0;
        else        ucnt_q <= ucnt_d;
    end

    assign underrun_count = ucnt_q;
`endif

endmodule

// File: tb/tb_rle_stream_decoder.sv
// Directed bench for rle_stream_decoder with a queue-based reference model
// checked every cycle plus literal expectations per scenario.
module tb_rle_stream_decoder;

    localparam int unsigned RUN_W   = 11;
    localparam int unsigned COLOR_W = 9;
    localparam int unsigned DEPTH   = 2;
    localparam logic [COLOR_W-1:0] BLANK = 9'h000;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [RUN_W+COLOR_W-1:0] instr_data = '0;
    logic                     instr_valid = 1'b0;
    logic                     instr_ready;
    logic                     pixel_en = 1'b0;
    logic                     blank = 1'b0;
    logic                     frame_start = 1'b0;
    logic [COLOR_W-1:0]       color_out;
    logic                     color_valid;
    logic                     underrun;
    logic [1:0]               fifo_level;
`ifdef RLE_UNDERRUN_CNT_EN
    logic [15:0]              underrun_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    rle_stream_decoder #(
        .RUN_W       (RUN_W),
        .COLOR_W     (COLOR_W),
        .FIFO_DEPTH  (DEPTH),
        .BLANK_COLOR (BLANK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_data  (instr_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pixel_en    (pixel_en),
        .blank       (blank),
        .frame_start (frame_start),
        .color_out   (color_out),
        .color_valid (color_valid),
        .underrun    (underrun),
`ifdef RLE_UNDERRUN_CNT_EN
        .underrun_count (underrun_count),
`endif
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, active run as pixels still owed.
    logic [19:0] mq[$];
    int          m_left = 0;
    logic [8:0]  m_cur = '0;
    logic [8:0]  m_out = '0;
    bit          m_valid = 0;
    bit          m_und = 0;
    int          m_ucnt = 0;

    task automatic m_load();
        logic [19:0] e;
        e = mq.pop_front();
        m_cur  = e[8:0];
        m_left = int'(e[19:9]) + 1;
    endtask

    task automatic model_step();
        bit was_idle, do_push;
        if (!rst_n) begin
            mq.delete(); m_left = 0; m_cur = BLANK; m_out = BLANK;
            m_valid = 0; m_und = 0; m_ucnt = 0;
        end else if (frame_start) begin
            mq.delete(); m_left = 0; m_out = BLANK;
            m_valid = 0; m_und = 0; m_ucnt = 0;
        end else begin
            do_push  = instr_valid && (mq.size() < DEPTH);
            was_idle = (m_left == 0);
            m_und    = 0;
            if (pixel_en && blank) begin
                m_out = BLANK; m_valid = 0;
            end else if (pixel_en && !was_idle) begin
                m_out = m_cur; m_valid = 1;
                m_left--;
                if (m_left == 0 && mq.size() > 0) m_load();
            end else if (pixel_en) begin
                m_out = BLANK; m_valid = 0; m_und = 1;
                if (m_ucnt != 65535) m_ucnt++;
            end
            if (was_idle && mq.size() > 0) m_load();
            if (do_push) mq.push_back(instr_data);
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("model color_out", 32'(color_out), 32'(m_out));
        chk("model color_valid", 32'(color_valid), 32'(m_valid));
        chk("model underrun", 32'(underrun), 32'(m_und));
        chk("model fifo_level", 32'(fifo_level), mq.size());
        chk("model instr_ready", 32'(instr_ready), 32'(mq.size() < DEPTH && !frame_start));
`ifdef RLE_UNDERRUN_CNT_EN
        chk("model underrun_count", 32'(underrun_count), m_ucnt);
`endif
    end

    function automatic logic [19:0] ins(input int r, input int c);
        logic [31:0] rv, cv;
        rv = r; cv = c;
        return {rv[10:0], cv[8:0]};
    endfunction

    task automatic cyc(input bit pe, input bit bl, input bit fs, input bit iv, input logic [19:0] d);
        pixel_en = pe; blank = bl; frame_start = fs; instr_valid = iv; instr_data = d;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        logic [8:0] exp2 [4];
        int nv;
        exp2[0] = 9'h007; exp2[1] = 9'h038; exp2[2] = 9'h1FF; exp2[3] = 9'h1FF;

        repeat (3) @(negedge clk);
        chk("reset color_out", 32'(color_out), 32'h0);
        chk("reset color_valid", 32'(color_valid), 32'h0);
        chk("reset underrun", 32'(underrun), 32'h0);
        chk("reset fifo_level", 32'(fifo_level), 32'h0);
        rst_n = 1'b1;

        // Single run of three pixels, then underrun
        cyc(0, 0, 0, 1, ins(2, 'h1C0));
        chk("t1 level after push", 32'(fifo_level), 32'd1);
        cyc(0, 0, 0, 0, '0);
        chk("t1 level after preload", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, '0);
            chk("t1 color", 32'(color_out), 32'h1C0);
            chk("t1 valid", 32'(color_valid), 32'd1);
        end
        cyc(1, 0, 0, 0, '0);
        chk("t1 underrun", 32'(underrun), 32'd1);
        chk("t1 underrun valid", 32'(color_valid), 32'd0);
        chk("t1 underrun color", 32'(color_out), 32'h0);
        cyc(0, 0, 0, 0, '0);
        chk("t1 underrun one-shot", 32'(underrun), 32'd0);

        // Back-to-back short runs with a full FIFO
        cyc(0, 0, 0, 1, ins(0, 'h007));
        cyc(0, 0, 0, 1, ins(0, 'h038));
        cyc(0, 0, 0, 1, ins(1, 'h1FF));
        chk("t2 level full", 32'(fifo_level), 32'd2);
        chk("t2 ready while full", 32'(instr_ready), 32'd0);
        cyc(0, 0, 0, 1, ins(5, 'h003));
        chk("t2 refused push", 32'(fifo_level), 32'd2);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, '0);
            chk("t2 color", 32'(color_out), 32'(exp2[i]));
            chk("t2 valid", 32'(color_valid), 32'd1);
        end
        cyc(1, 0, 0, 0, '0);
        chk("t2 underrun", 32'(underrun), 32'd1);

        // Blanking in mid-run leaves the run intact
        cyc(0, 0, 0, 1, ins(3, 'h0AA));
        cyc(0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        chk("t3 first pixel", 32'(color_out), 32'h0AA);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 0, 0, '0);
            chk("t3 blank color", 32'(color_out), 32'h0);
            chk("t3 blank valid", 32'(color_valid), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, '0);
            chk("t3 resumed pixel", 32'(color_out), 32'h0AA);
            chk("t3 resumed valid", 32'(color_valid), 32'd1);
        end
        cyc(1, 0, 0, 0, '0);
        chk("t3 underrun", 32'(underrun), 32'd1);

        // Frame flush with pixel_en and instr_valid asserted together
        cyc(0, 0, 0, 1, ins(5, 'h011));
        cyc(0, 0, 0, 1, ins(1, 'h022));
        cyc(0, 0, 0, 1, ins(1, 'h033));
        cyc(1, 0, 0, 0, '0);
        chk("t4 level before flush", 32'(fifo_level), 32'd2);
        chk("t4 mid-run color", 32'(color_out), 32'h011);
        pixel_en = 1; blank = 0; frame_start = 1; instr_valid = 1; instr_data = ins(0, 'h044);
        #1;
        chk("t4 ready during flush", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("t4 level after flush", 32'(fifo_level), 32'd0);
        chk("t4 valid after flush", 32'(color_valid), 32'd0);
        chk("t4 color after flush", 32'(color_out), 32'h0);
        cyc(1, 0, 0, 0, '0);
        chk("t4 underrun after flush", 32'(underrun), 32'd1);

        // Longest run: 2048 pixels exactly
        cyc(0, 0, 0, 1, ins(2047, 'h155));
        cyc(0, 0, 0, 0, '0);
        nv = 0;
        for (int i = 0; i < 2048; i++) begin
            cyc(1, 0, 0, 0, '0);
            if (color_valid === 1'b1 && color_out === 9'h155) nv++;
        end
        chk("t5 pixel count", nv, 32'd2048);
        cyc(1, 0, 0, 0, '0);
        chk("t5 underrun", 32'(underrun), 32'd1);

        // Underrun burst and counter clear
        cyc(0, 0, 1, 0, '0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, '0);
        chk("t6 last underrun", 32'(underrun), 32'd1);
`ifdef RLE_UNDERRUN_CNT_EN
        chk("t6 underrun_count", 32'(underrun_count), 32'd5);
        cyc(0, 0, 1, 0, '0);
        chk("t6 underrun_count clear", 32'(underrun_count), 32'd0);
`endif

        // Mixed traffic: concurrent push/pop, blanking and gaps
        for (int i = 0; i < 80; i++) begin
            cyc((i % 3) != 0, (i % 7) == 3, i == 61, (i % 2) == 0, ins(i % 4, i * 37));
        end
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
